uart_cmd_ctrl: RTL and testbench

Command-frame controller that sits directly behind the 8N1 UART receiver and sequences it. It gates the receiver's enable and collects two consecutive bytes: a command code followed by a sensor address. It validates the pair, enforces an inter-byte timeout, and presents the accepted command to the sensor scheduler through a valid/ready handshake. While a command awaits acceptance, the receiver is held disabled, so new frames cannot overwrite it.

---
 rtl/uart_cmd_ctrl.sv | 135 +++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: sequences a UART receiver to collect a two-byte
// command frame (command code, then sensor address), validates it,
// enforces an inter-byte timeout and hands the command to a scheduler
// over a valid/ready handshake.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   rx_done, rx_data    byte-complete pulse and byte from the receiver
//   rx_en               receiver enable (low while a command is pending)
//   cmd_valid/ready     handshake to the scheduler
//   cmd_code, cmd_addr  accepted command byte and 5-bit sensor address
//   err_pulse, err_code one-cycle error strobe and last error code
//   frames_ok/err       wrapping accepted / error frame counters
module uart_cmd_ctrl #(
    parameter int         TIMEOUT_CYCLES = 138880,
    parameter logic [7:0] CMD_MAX        = 8'h06
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic       rx_en,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] cmd_code,
    output logic [4:0] cmd_addr,
    output logic       err_pulse,
    output logic [1:0] err_code,
    output logic [7:0] frames_ok,
    output logic [7:0] frames_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_BAD_CMD = 2'b10;
    localparam logic [1:0] ERR_BAD_ADR = 2'b11;

    typedef enum logic [2:0] {
        WAIT_CMD,
        WAIT_ADDR,
        CHECK,
        DISPATCH,
        ERROR
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [7:0]    cmd_reg;
    logic [7:0]    addr_reg;

    // Outputs are registered, so each transition sets the values the
    // destination state must present in its first cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_CMD;
            timer      <= '0;
            cmd_reg    <= '0;
            addr_reg   <= '0;
            rx_en      <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_code   <= '0;
            cmd_addr   <= '0;
            err_pulse  <= 1'b0;
            err_code   <= '0;
            frames_ok  <= '0;
            frames_err <= '0;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                WAIT_CMD: begin
                    rx_en <= 1'b1;
                    if (rx_done) begin
                        cmd_reg <= rx_data;
                        timer   <= '0;
                        state   <= WAIT_ADDR;
                    end
                end
                WAIT_ADDR: begin
                    rx_en <= 1'b1;
                    timer <= timer + 1'b1;
                    // A byte landing on the final count beats the timeout.
                    if (rx_done) begin
                        addr_reg <= rx_data;
                        state    <= CHECK;
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        rx_en      <= 1'b0;
                        err_pulse  <= 1'b1;
                        err_code   <= ERR_TIMEOUT;
                        frames_err <= frames_err + 8'd1;
                        state      <= ERROR;
                    end
                end
                CHECK: begin
                    // Receiver is parked from here until the frame retires.
                    rx_en <= 1'b0;
                    if (cmd_reg > CMD_MAX) begin
                        err_pulse  <= 1'b1;
                        err_code   <= ERR_BAD_CMD;
                        frames_err <= frames_err + 8'd1;
                        state      <= ERROR;
                    end else if (addr_reg[7:5] != 3'b000) begin
                        err_pulse  <= 1'b1;
                        err_code   <= ERR_BAD_ADR;
                        frames_err <= frames_err + 8'd1;
                        state      <= ERROR;
                    end else begin
                        cmd_valid <= 1'b1;
                        cmd_code  <= cmd_reg;
                        cmd_addr  <= addr_reg[4:0];
                        state     <= DISPATCH;
                    end
                end
                DISPATCH: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        rx_en     <= 1'b1;
                        frames_ok <= frames_ok + 8'd1;
                        state     <= WAIT_CMD;
                    end
                end
                ERROR: begin
                    rx_en <= 1'b1;
                    state <= WAIT_CMD;
                end
                default: begin
                    rx_en     <= 1'b0;
                    cmd_valid <= 1'b0;
                    state     <= WAIT_CMD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed bench for uart_cmd_ctrl with a
// 100-cycle inter-byte timeout.
module tb_uart_cmd_ctrl;

    logic       clk;
    logic       rst;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       rx_en;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_code;
    logic [4:0] cmd_addr;
    logic       err_pulse;
    logic [1:0] err_code;
    logic [7:0] frames_ok;
    logic [7:0] frames_err;

    int checks;
    int failures;

    uart_cmd_ctrl #(
        .TIMEOUT_CYCLES(100),
        .CMD_MAX       (8'h06)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_done   (rx_done),
        .rx_data   (rx_data),
        .rx_en     (rx_en),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_code  (cmd_code),
        .cmd_addr  (cmd_addr),
        .err_pulse (err_pulse),
        .err_code  (err_code),
        .frames_ok (frames_ok),
        .frames_err(frames_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; rx_done is high for that one cycle.
    task automatic send_byte(input logic [7:0] b);
        rx_done = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    logic [7:0] exp_ok;
    logic [7:0] exp_err;
    logic [7:0] wc;
    logic [7:0] wa;
    logic [14:0] snap;

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        rx_done   = 1'b0;
        rx_data   = 8'h00;
        cmd_ready = 1'b1;
        exp_ok    = 8'd0;
        exp_err   = 8'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rx_en", 32'(rx_en), 32'd0);
        chk("rst_valid", 32'(cmd_valid), 32'd0);
        chk("rst_cnts", 32'({frames_ok, frames_err}), 32'd0);
        chk("rst_err", 32'({err_pulse, err_code}), 32'd0);
        chk("rst_cmd", 32'({cmd_code, cmd_addr}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_rx_en", 32'(rx_en), 32'd1);

        // Valid frame, zero-wait acceptance
        send_byte(8'h03);
        send_byte(8'h1F);
        chk("v_check_valid", 32'(cmd_valid), 32'd0);
        chk("v_check_rx_en", 32'(rx_en), 32'd1);
        @(negedge clk);
        chk("v_valid", 32'(cmd_valid), 32'd1);
        chk("v_code", 32'(cmd_code), 32'h03);
        chk("v_addr", 32'(cmd_addr), 32'd31);
        chk("v_rx_en", 32'(rx_en), 32'd0);
        chk("v_errp", 32'(err_pulse), 32'd0);
        @(negedge clk);
        exp_ok = exp_ok + 8'd1;
        chk("v_pulse_end", 32'(cmd_valid), 32'd0);
        chk("v_rx_en_back", 32'(rx_en), 32'd1);
        chk("v_ok", 32'(frames_ok), 32'(exp_ok));
        chk("v_err_cnt", 32'(frames_err), 32'd0);

        // Backpressure for 50 cycles with a stray line byte
        cmd_ready = 1'b0;
        send_byte(8'h01);
        send_byte(8'h05);
        @(negedge clk);
        snap = {1'b1, 1'b0, 8'h01, 5'd5};
        for (int i = 0; i < 50; i++) begin
            chk("bp_hold", 32'({cmd_valid, rx_en, cmd_code, cmd_addr}),
                32'(snap));
            rx_done = (i == 20);
            rx_data = (i == 20) ? 8'h41 : 8'h00;
            @(negedge clk);
        end
        rx_done = 1'b0;
        chk("bp_ok_held", 32'(frames_ok), 32'(exp_ok));
        cmd_ready = 1'b1;
        @(negedge clk);
        exp_ok = exp_ok + 8'd1;
        chk("bp_valid_drop", 32'(cmd_valid), 32'd0);
        chk("bp_rx_en", 32'(rx_en), 32'd1);
        chk("bp_ok", 32'(frames_ok), 32'(exp_ok));

        // Bad command
        send_byte(8'h07);
        send_byte(8'h00);
        @(negedge clk);
        exp_err = exp_err + 8'd1;
        chk("bc_pulse", 32'(err_pulse), 32'd1);
        chk("bc_code", 32'(err_code), 32'h2);
        chk("bc_cnt", 32'(frames_err), 32'(exp_err));
        chk("bc_valid", 32'(cmd_valid), 32'd0);
        chk("bc_rx_en", 32'(rx_en), 32'd0);
        @(negedge clk);
        chk("bc_pulse_end", 32'(err_pulse), 32'd0);
        chk("bc_rx_en_back", 32'(rx_en), 32'd1);
        chk("bc_ok", 32'(frames_ok), 32'(exp_ok));

        // Bad address
        send_byte(8'h02);
        send_byte(8'h20);
        @(negedge clk);
        exp_err = exp_err + 8'd1;
        chk("ba_pulse", 32'(err_pulse), 32'd1);
        chk("ba_code", 32'(err_code), 32'h3);
        chk("ba_cnt", 32'(frames_err), 32'(exp_err));
        @(negedge clk);

        // Bad command outranks bad address
        send_byte(8'h09);
        send_byte(8'h40);
        @(negedge clk);
        exp_err = exp_err + 8'd1;
        chk("pr_pulse", 32'(err_pulse), 32'd1);
        chk("pr_code", 32'(err_code), 32'h2);
        chk("pr_cnt", 32'(frames_err), 32'(exp_err));
        @(negedge clk);

        // Timeout: byte 1 at C, pulse at C+101
        send_byte(8'h00);
        repeat (99) @(negedge clk);
        chk("to_early", 32'(err_pulse), 32'd0);
        chk("to_rx_en", 32'(rx_en), 32'd1);
        @(negedge clk);
        exp_err = exp_err + 8'd1;
        chk("to_pulse", 32'(err_pulse), 32'd1);
        chk("to_code", 32'(err_code), 32'h1);
        chk("to_cnt", 32'(frames_err), 32'(exp_err));
        @(negedge clk);
        chk("to_pulse_end", 32'(err_pulse), 32'd0);
        chk("to_resume", 32'(rx_en), 32'd1);

        // Timeout boundary: byte 2 at C+100 is accepted
        send_byte(8'h04);
        repeat (99) @(negedge clk);
        send_byte(8'h0A);
        chk("tb_no_err", 32'(err_pulse), 32'd0);
        @(negedge clk);
        chk("tb_valid", 32'(cmd_valid), 32'd1);
        chk("tb_cmd", 32'({cmd_code, cmd_addr}), 32'({8'h04, 5'd10}));
        chk("tb_err_cnt", 32'(frames_err), 32'(exp_err));
        @(negedge clk);
        exp_ok = exp_ok + 8'd1;
        chk("tb_ok", 32'(frames_ok), 32'(exp_ok));

        // Reset while a command is pending
        cmd_ready = 1'b0;
        send_byte(8'h05);
        send_byte(8'h03);
        @(negedge clk);
        chk("rd_pending", 32'(cmd_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rd_outs", 32'({rx_en, cmd_valid, cmd_code, cmd_addr,
                            err_pulse, err_code}), 32'd0);
        chk("rd_cnts", 32'({frames_ok, frames_err}), 32'd0);
        rst       = 1'b0;
        cmd_ready = 1'b1;
        exp_ok    = 8'd0;
        exp_err   = 8'd0;
        @(negedge clk);
        chk("rd_rx_en", 32'(rx_en), 32'd1);
        repeat (3) @(negedge clk);
        chk("rd_no_accept", 32'({cmd_valid, frames_ok}), 32'd0);

        // 256 frames wrap the accepted counter
        for (int i = 0; i < 256; i++) begin
            wc = 8'(i % 7);
            wa = 8'(i % 32);
            send_byte(wc);
            send_byte(wa);
            @(negedge clk);
            chk("wr_frame", 32'({cmd_valid, cmd_code, cmd_addr}),
                32'({1'b1, wc, wa[4:0]}));
            @(negedge clk);
            exp_ok = exp_ok + 8'd1;
            if (i == 254)
                chk("wr_255", 32'(frames_ok), 32'd255);
        end
        chk("wr_wrap", 32'(frames_ok), 32'(exp_ok));
        chk("wr_zero", 32'(frames_ok), 32'd0);
        chk("wr_err_cnt", 32'(frames_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
